// File: rtl/my_ram.sv
// my_ram: 64x32 CPU register file, two async read ports, one sync write port.
// Optional write-to-read forwarding is enabled by defining MYRAM_BYPASS_EN.
module my_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [ADDR_W-1:0] address_w,
    input  logic [DATA_W-1:0] busW,
    input  logic              RegWr,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = RegWr && (address_w != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[address_w] <= busW;
        end
    end

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Location 0 reads zero regardless of storage contents.
    assign rd_a = (address_a == '0) ? '0 : mem[address_a];
    assign rd_b = (address_b == '0) ? '0 : mem[address_b];

`ifdef MYRAM_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    assign fwd_a = !rst && wr_ok && (address_w == address_a);
    assign fwd_b = !rst && wr_ok && (address_w == address_b);

    always_comb begin
        busA = fwd_a ? busW : rd_a;
        busB = fwd_b ? busW : rd_b;
    end
`else
    always_comb begin
        busA = rd_a;
        busB = rd_b;
    end
`endif

endmodule

// File: tb/tb_my_ram.sv
// tb_my_ram: directed self-checking bench for the my_ram register file.
// Expectations before a write edge depend on MYRAM_BYPASS_EN.
module tb_my_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

`ifdef MYRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address_a;
    logic [ADDR_W-1:0] address_b;
    logic [ADDR_W-1:0] address_w;
    logic [DATA_W-1:0] busW;
    logic              RegWr;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;

    int n_vec = 0;
    int n_bad = 0;

    my_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .address_a (address_a),
        .address_b (address_b),
        .address_w (address_w),
        .busW      (busW),
        .RegWr     (RegWr),
        .busA      (busA),
        .busB      (busB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        address_w = a;
        busW      = d;
        RegWr     = 1'b1;
        @(posedge clk);
        #1;
        RegWr     = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        address_a = '0;
        address_b = '0;
        address_w = '0;
        busW      = '0;
        RegWr     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        address_a = 6'd1;
        address_b = 6'd4;
        #1;
        check("rst_a1", busA, 32'h0);
        check("rst_b4", busB, 32'h0);
        address_a = 6'd63;
        address_b = 6'd63;
        #1;
        check("rst_a63", busA, 32'h0);
        check("rst_b63", busB, 32'h0);

        // basic write / read
        address_a = 6'd2;
        address_b = 6'd3;
        wr(6'd4, 32'd3);
        check("basic_a2", busA, 32'h0);
        check("basic_b3", busB, 32'h0);
        address_a = 6'd4;
        #1;
        check("basic_a4", busA, 32'd3);

        // zero register, never forwarded either
        address_a = 6'd0;
        address_w = 6'd0;
        busW      = 32'hDEADBEEF;
        RegWr     = 1'b1;
        #1;
        check("zero_pre", busA, 32'h0);
        @(posedge clk);
        #1;
        RegWr = 1'b0;
        check("zero_post", busA, 32'h0);

        // write disable
        address_w = 6'd5;
        busW      = 32'd7;
        RegWr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        address_a = 6'd5;
        #1;
        check("wdis_5", busA, 32'h0);

        // dual read and boundaries
        wr(6'd1, 32'h11111111);
        wr(6'd63, 32'hFFFFFFFF);
        address_a = 6'd1;
        address_b = 6'd63;
        #1;
        check("dual_a1", busA, 32'h11111111);
        check("dual_b63", busB, 32'hFFFFFFFF);
        address_a = 6'd63;
        #1;
        check("same_a63", busA, 32'hFFFFFFFF);
        check("same_b63", busB, 32'hFFFFFFFF);
        address_b = 6'd4;
        #1;
        check("keep_b4", busB, 32'd3);

        // back-to-back writes, last wins
        wr(6'd7, 32'h0000000A);
        wr(6'd7, 32'h0000000B);
        address_a = 6'd7;
        #1;
        check("b2b_7", busA, 32'h0000000B);

        // read during write
        address_a = 6'd9;
        address_b = 6'd9;
        address_w = 6'd9;
        busW      = 32'h55;
        RegWr     = 1'b1;
        #1;
        check("rdw_pre_a", busA, BYP ? 32'h55 : 32'h0);
        check("rdw_pre_b", busB, BYP ? 32'h55 : 32'h0);
        @(posedge clk);
        #1;
        check("rdw_post", busA, 32'h55);

        // reset beats a simultaneous write; no forwarding during reset
        rst  = 1'b1;
        busW = 32'h66;
        #1;
        check("rst_pre", busA, 32'h55);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        RegWr = 1'b0;
        #1;
        check("rst_post9", busA, 32'h0);
        address_a = 6'd63;
        address_b = 6'd1;
        #1;
        check("rst_post63", busA, 32'h0);
        check("rst_post1", busB, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
